pong_collision: RTL and testbench
=================================

Name: pong_collision

Overview:
- Upstream stage of the ball position update. Each frame it inspects the current ball position against walls and both paddles, and drives the single-cycle touching_paddle and touching_wall pulses that the ball stage uses to flip its direction signs.
- Also detects misses, keeps both scores, and runs the serve/point/game-over sequence.
- Sits between the paddle controllers and position registers on one side and the ball update stage on the other.

Parameters:
- X_W, 10, ball/paddle x coordinate width
- Y_W, 10, ball/paddle y coordinate width
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- BALL_SIZE, 8, ball edge length
- PADDLE_W, 8, paddle width
- PADDLE_H, 48, paddle height
- LEFT_PADDLE_X, 16, left paddle left edge x
- RIGHT_PADDLE_X, 616, right paddle left edge x
- SCORE_W, 4, score counter width
- WIN_SCORE, 9, score that ends the game
- SERVE_DELAY, 60, frame ticks spent in SERVE before play resumes

Ports:
- clk, in, 1, clock
- reset, in, 1, synchronous, active-high
- frame_tick, in, 1, one-cycle pulse per frame; the ball position is valid and stable in that cycle
- ball_x, in, X_W, ball top-left x
- ball_y, in, Y_W, ball top-left y
- left_paddle_y, in, Y_W, left paddle top y
- right_paddle_y, in, Y_W, right paddle top y
- touching_paddle, out, 1, one-cycle pulse: reverse x direction
- touching_wall, out, 1, one-cycle pulse: reverse y direction
- serve, out, 1, one-cycle pulse: downstream reloads the ball at screen centre
- score_left, out, SCORE_W, left player score
- score_right, out, SCORE_W, right player score
- game_over, out, 1, high while in GAME_OVER

Behaviour:
- Reset values: all outputs 0; state SERVE; serve counter 0; both contact-armed flags 1.
- Evaluation timing: geometry is evaluated only in cycles where frame_tick=1. Pulses are registered and appear exactly one clk after that frame_tick, lasting one cycle. Outputs never stay high for two cycles, because the ball stage toggles its sign on every high cycle.
- Wall contact: true when ball_y == 0, or ball_y + BALL_SIZE >= SCREEN_H.
  - Compute the sum at Y_W+1 bits.
  - ball_y >= SCREEN_H (the result of an unsigned wrap below 0) also counts as wall contact.
- Paddle contact (per paddle): x intervals [ball_x, ball_x+BALL_SIZE) and [PX, PX+PADDLE_W) overlap, and y intervals [ball_y, ball_y+BALL_SIZE) and [py, py+PADDLE_H) overlap. All sums are evaluated at width+1 bits. touching_paddle is the OR over both paddles.
- Lockout (armed flags):
  - A pulse fires only if the corresponding armed flag is 1; firing clears the flag.
  - The flag re-arms on the first frame_tick at which that contact condition is false.
  - This prevents a double flip while the ball still overlaps after a bounce. The wall and paddle flags are independent.
- Miss:
  - ball_x < LEFT_PADDLE_X, or ball_x >= SCREEN_W (wrapped): right player scores.
  - ball_x + BALL_SIZE > RIGHT_PADDLE_X + PADDLE_W: left player scores.
  - Paddle contact in the same frame takes priority, so no miss is recorded.
- FSM states: SERVE, PLAY, POINT, GAME_OVER.
  - SERVE:
    - Counts frame_ticks. At count == SERVE_DELAY-1 with frame_tick, pulse serve for one cycle, clear the counter, re-arm both flags, and go to PLAY.
    - No touching pulses are issued in SERVE.
  - PLAY: collision evaluation as above. A miss on a frame_tick goes to POINT, latching which side scored. Any wall or paddle pulse for that same frame is still issued.
  - POINT (one cycle):
    - Increment the scoring side's counter.
    - If the new value == WIN_SCORE, go to GAME_OVER; else go to SERVE.
    - Counters saturate at WIN_SCORE and never wrap.
  - GAME_OVER: game_over=1. No pulses, no serve. Scores are held. Leaves only on reset.
- Simultaneous wall and paddle contact (corner hit): both pulses in the same cycle.
- Reset mid-frame or mid-POINT: the next cycle is in reset state; any pending pulse is dropped and scores are cleared.
- frame_tick during the POINT cycle is ignored.

Decomposition:
- pong_pkg:
  - game_state_t enum {SERVE, PLAY, POINT, GAME_OVER}
  - screen, ball and paddle geometry constants (shared with the ball stage and renderer)
  - side_t enum {SIDE_LEFT, SIDE_RIGHT}
- Sub-module pong_paddle_hit: one paddle's overlap compare plus armed flag. It outputs the armed contact pulse request and a raw miss-side compare. Instantiated twice with PX=LEFT_PADDLE_X and RIGHT_PADDLE_X.

Test Plan:
- Serve: reset, then 60 frame_ticks → serve pulses once, one clk after the 60th tick; touching_* stay 0 throughout; state PLAY.
- Top wall: ball_y=0, ball_x=320 on a tick → touching_wall=1 for exactly one cycle. The next tick with ball_y=0 → no pulse. Ball_y=10 → re-arm; ball_y=0 again → pulse.
- Left paddle: left_paddle_y=200, ball_x=20, ball_y=210 → touching_paddle one-cycle pulse. Repeat the same position next tick → no pulse.
- Corner: ball_x=20, ball_y=0, left_paddle_y=0 → touching_paddle and touching_wall pulse in the same cycle.
- Miss and wrap: left_paddle_y=300, ball_x=1018 (wrapped) → score_right 0→1, then SERVE. Ball_x=8 also scores for the right player.
- Game over: pre-drive score_left to 8, then a right-side miss (ball_x=630) → score_left=9, game_over=1. Further ticks produce no pulses; reset clears scores and game_over.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong types and default playfield geometry.
package pong_pkg;

  typedef enum logic [1:0] {SERVE, PLAY, POINT, GAME_OVER} game_state_t;
  typedef enum logic {SIDE_LEFT, SIDE_RIGHT} side_t;

  localparam int PONG_X_W           = 10;
  localparam int PONG_Y_W           = 10;
  localparam int PONG_SCREEN_W      = 640;
  localparam int PONG_SCREEN_H      = 480;
  localparam int PONG_BALL_SIZE     = 8;
  localparam int PONG_PADDLE_W      = 8;
  localparam int PONG_PADDLE_H      = 48;
  localparam int PONG_LEFT_PADDLE_X = 16;
  localparam int PONG_RIGHT_PADDLE_X= 616;
  localparam int PONG_SCORE_W       = 4;
  localparam int PONG_WIN_SCORE     = 9;
  localparam int PONG_SERVE_DELAY   = 60;

endpackage

// File: rtl/pong_paddle_hit.sv
// One paddle: box overlap test, contact lockout flag and the miss compare
// for the goal line behind this paddle.
module pong_paddle_hit
  import pong_pkg::*;
#(
  parameter int    X_W       = PONG_X_W,
  parameter int    Y_W       = PONG_Y_W,
  parameter int    SCREEN_W  = PONG_SCREEN_W,
  parameter int    BALL_SIZE = PONG_BALL_SIZE,
  parameter int    PADDLE_W  = PONG_PADDLE_W,
  parameter int    PADDLE_H  = PONG_PADDLE_H,
  parameter int    PX        = PONG_LEFT_PADDLE_X,
  parameter side_t SIDE      = SIDE_LEFT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           eval,      // frame_tick while in PLAY
  input  logic           rearm,     // serve completes
  input  logic [X_W-1:0] ball_x,
  input  logic [Y_W-1:0] ball_y,
  input  logic [Y_W-1:0] paddle_y,
  output logic           hit,       // armed contact: request a pulse
  output logic           contact,   // raw overlap
  output logic           miss       // ball is past this paddle's goal line
);

  logic       armed;
  logic [X_W:0] bx_lo, bx_hi, px_lo, px_hi;
  logic [Y_W:0] by_lo, by_hi, py_lo, py_hi;

  // One extra bit keeps the far edges from wrapping.
  assign bx_lo = {1'b0, ball_x};
  assign bx_hi = bx_lo + (X_W+1)'(BALL_SIZE);
  assign px_lo = (X_W+1)'(PX);
  assign px_hi = (X_W+1)'(PX + PADDLE_W);
  assign by_lo = {1'b0, ball_y};
  assign by_hi = by_lo + (Y_W+1)'(BALL_SIZE);
  assign py_lo = {1'b0, paddle_y};
  assign py_hi = py_lo + (Y_W+1)'(PADDLE_H);

  assign contact = (bx_lo < px_hi) && (px_lo < bx_hi) &&
                   (by_lo < py_hi) && (py_lo < by_hi);
  assign hit     = armed && contact;

  // Left goal also catches x that wrapped below zero; right goal is the far edge.
  if (SIDE == SIDE_LEFT) begin : g_left
    assign miss = (bx_lo < px_lo) || (bx_lo >= (X_W+1)'(SCREEN_W));
  end else begin : g_right
    assign miss = (bx_hi > px_hi);
  end

  // Lockout: any evaluated contact disarms, first contact-free frame re-arms.
  always_ff @(posedge clk) begin
    if (reset)      armed <= 1'b1;
    else if (rearm) armed <= 1'b1;
    else if (eval)  armed <= !contact;
  end

endmodule

// File: rtl/pong_collision.sv
// Per-frame wall/paddle collision pulses, miss detection, scoring and the
// serve/point/game-over sequence.
module pong_collision
  import pong_pkg::*;
#(
  parameter int X_W            = PONG_X_W,
  parameter int Y_W            = PONG_Y_W,
  parameter int SCREEN_W       = PONG_SCREEN_W,
  parameter int SCREEN_H       = PONG_SCREEN_H,
  parameter int BALL_SIZE      = PONG_BALL_SIZE,
  parameter int PADDLE_W       = PONG_PADDLE_W,
  parameter int PADDLE_H       = PONG_PADDLE_H,
  parameter int LEFT_PADDLE_X  = PONG_LEFT_PADDLE_X,
  parameter int RIGHT_PADDLE_X = PONG_RIGHT_PADDLE_X,
  parameter int SCORE_W        = PONG_SCORE_W,
  parameter int WIN_SCORE      = PONG_WIN_SCORE,
  parameter int SERVE_DELAY    = PONG_SERVE_DELAY
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [X_W-1:0]     ball_x,
  input  logic [Y_W-1:0]     ball_y,
  input  logic [Y_W-1:0]     left_paddle_y,
  input  logic [Y_W-1:0]     right_paddle_y,
  output logic               touching_paddle,
  output logic               touching_wall,
  output logic               serve,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over
);

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  game_state_t        state;
  side_t              scorer;
  logic [CNT_W-1:0]   serve_cnt;
  logic               wall_armed;
  logic [Y_W:0]       by_lo, by_hi;
  logic               wall, eval, serve_done;
  logic               hit_l, hit_r, con_l, con_r, miss_l, miss_r;
  logic [SCORE_W-1:0] pts;

  assign by_lo = {1'b0, ball_y};
  assign by_hi = by_lo + (Y_W+1)'(BALL_SIZE);
  // y >= SCREEN_H means the ball wrapped above the top edge.
  assign wall  = (ball_y == '0) || (by_hi >= (Y_W+1)'(SCREEN_H)) ||
                 (by_lo >= (Y_W+1)'(SCREEN_H));

  assign eval       = frame_tick && (state == PLAY);
  assign serve_done = frame_tick && (state == SERVE) &&
                      (serve_cnt == CNT_W'(SERVE_DELAY - 1));

  pong_paddle_hit #(
    .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SCREEN_W), .BALL_SIZE(BALL_SIZE),
    .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H), .PX(LEFT_PADDLE_X), .SIDE(SIDE_LEFT)
  ) u_left (
    .clk(clk), .reset(reset), .eval(eval), .rearm(serve_done),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_y(left_paddle_y),
    .hit(hit_l), .contact(con_l), .miss(miss_l)
  );

  pong_paddle_hit #(
    .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SCREEN_W), .BALL_SIZE(BALL_SIZE),
    .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H), .PX(RIGHT_PADDLE_X), .SIDE(SIDE_RIGHT)
  ) u_right (
    .clk(clk), .reset(reset), .eval(eval), .rearm(serve_done),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_y(right_paddle_y),
    .hit(hit_r), .contact(con_r), .miss(miss_r)
  );

  // Scoring side's next value, saturating at WIN_SCORE.
  always_comb begin
    pts = (scorer == SIDE_LEFT) ? score_left : score_right;
    if (pts != SCORE_W'(WIN_SCORE)) pts = pts + 1'b1;
  end

  // Game FSM with registered single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= SERVE;
      scorer          <= SIDE_LEFT;
      serve_cnt       <= '0;
      wall_armed      <= 1'b1;
      touching_paddle <= 1'b0;
      touching_wall   <= 1'b0;
      serve           <= 1'b0;
      score_left      <= '0;
      score_right     <= '0;
      game_over       <= 1'b0;
    end else begin
      touching_paddle <= 1'b0;
      touching_wall   <= 1'b0;
      serve           <= 1'b0;
      case (state)
        SERVE: if (frame_tick) begin
          if (serve_done) begin
            serve      <= 1'b1;
            serve_cnt  <= '0;
            wall_armed <= 1'b1;
            state      <= PLAY;
          end else begin
            serve_cnt <= serve_cnt + 1'b1;
          end
        end
        PLAY: if (frame_tick) begin
          touching_paddle <= hit_l || hit_r;
          touching_wall   <= wall && wall_armed;
          wall_armed      <= !wall;
          // Paddle contact overrides a miss; a wrapped x counts as a left-goal miss.
          if (!(con_l || con_r) && (miss_l || miss_r)) begin
            state  <= POINT;
            scorer <= miss_l ? SIDE_RIGHT : SIDE_LEFT;
          end
        end
        POINT: begin
          if (scorer == SIDE_LEFT) score_left  <= pts;
          else                     score_right <= pts;
          if (pts == SCORE_W'(WIN_SCORE)) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
          end else begin
            state <= SERVE;
          end
        end
        default: game_over <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_collision.sv
// Scoreboard bench for pong_collision: directed frames push expected
// outputs, a monitor pops and compares on the cycle they are due.
module tb_pong_collision;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [9:0] ball_x, ball_y, left_paddle_y, right_paddle_y;
  logic       touching_paddle, touching_wall, serve, game_over;
  logic [3:0] score_left, score_right;

  pong_collision dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .ball_x(ball_x), .ball_y(ball_y),
    .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
    .touching_paddle(touching_paddle), .touching_wall(touching_wall),
    .serve(serve), .score_left(score_left), .score_right(score_right),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       tp, tw, sv;
    logic [3:0] sl, sr;
    logic       go;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] m_sl = 4'd0, m_sr = 4'd0;
  logic       m_go = 1'b0;

  task automatic push(input int due, input logic tp, input logic tw, input logic sv);
    exp_t e;
    e.due = due; e.tp = tp; e.tw = tw; e.sv = sv;
    e.sl = m_sl; e.sr = m_sr; e.go = m_go;
    q.push_back(e);
  endtask

  // One frame_tick; outputs are due on the following cycle.
  task automatic tick(input int bx, input int by, input logic tp, input logic tw, input logic sv);
    @(posedge clk); #1;
    ball_x = 10'(bx); ball_y = 10'(by); frame_tick = 1'b1;
    push(cyc + 1, tp, tw, sv);
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic expect_idle();
    @(posedge clk); #1;
    push(cyc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic serve_seq();
    repeat (59) tick(320, 240, 1'b0, 1'b0, 1'b0);
    tick(320, 240, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare due records; any pulse without a record is unexpected.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL stale_record due=%0d now=%0d", e.due, cyc);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      n_cmp++;
      if ({touching_paddle, touching_wall, serve, score_left, score_right, game_over} !==
          {e.tp, e.tw, e.sv, e.sl, e.sr, e.go}) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d tp/tw/sv/sl/sr/go got %b %b %b %0d %0d %b want %b %b %b %0d %0d %b",
                 cyc, touching_paddle, touching_wall, serve, score_left, score_right, game_over,
                 e.tp, e.tw, e.sv, e.sl, e.sr, e.go);
      end
    end else if (touching_paddle || touching_wall || serve) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_pulse cyc=%0d tp/tw/sv got %b %b %b want 0 0 0",
               cyc, touching_paddle, touching_wall, serve);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0;
    ball_x = 10'd320; ball_y = 10'd240;
    left_paddle_y = 10'd200; right_paddle_y = 10'd200;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    expect_idle();

    // Serve after 60 ticks
    serve_seq();

    // Top wall with lockout and re-arm
    tick(320, 0,   1'b0, 1'b1, 1'b0);
    tick(320, 0,   1'b0, 1'b0, 1'b0);
    tick(320, 10,  1'b0, 1'b0, 1'b0);
    tick(320, 0,   1'b0, 1'b1, 1'b0);
    tick(320, 100, 1'b0, 1'b0, 1'b0);
    // Bottom wall boundary: 471+8=479 no, 472+8=480 yes
    tick(320, 471, 1'b0, 1'b0, 1'b0);
    tick(320, 472, 1'b0, 1'b1, 1'b0);
    tick(320, 100, 1'b0, 1'b0, 1'b0);

    // Left paddle hit, lockout, re-arm, y edge boundary
    tick(20, 210,  1'b1, 1'b0, 1'b0);
    tick(20, 210,  1'b0, 1'b0, 1'b0);
    tick(320, 100, 1'b0, 1'b0, 1'b0);
    tick(20, 248,  1'b0, 1'b0, 1'b0);
    tick(20, 247,  1'b1, 1'b0, 1'b0);
    tick(320, 100, 1'b0, 1'b0, 1'b0);

    // Right paddle hit
    right_paddle_y = 10'd100;
    tick(610, 120, 1'b1, 1'b0, 1'b0);
    tick(320, 100, 1'b0, 1'b0, 1'b0);

    // Corner: paddle and wall together
    left_paddle_y = 10'd0;
    tick(20, 0,    1'b1, 1'b1, 1'b0);
    tick(320, 100, 1'b0, 1'b0, 1'b0);

    // Misses past the left paddle: wrapped x, low x, low x plus wall
    left_paddle_y = 10'd300;
    tick(1018, 100, 1'b0, 1'b0, 1'b0);
    m_sr = 4'd1;
    serve_seq();
    tick(8, 100, 1'b0, 1'b0, 1'b0);
    m_sr = 4'd2;
    serve_seq();
    tick(8, 0, 1'b0, 1'b1, 1'b0);
    m_sr = 4'd3;
    serve_seq();

    // Left player scores to WIN_SCORE
    for (int i = 1; i <= 9; i++) begin
      tick(630, 240, 1'b0, 1'b0, 1'b0);
      m_sl = 4'(i);
      if (i == 9) m_go = 1'b1;
      else        serve_seq();
    end

    // Game over: no pulses, no serve
    left_paddle_y = 10'd200;
    tick(320, 0,   1'b0, 1'b0, 1'b0);
    tick(20, 210,  1'b0, 1'b0, 1'b0);
    tick(630, 240, 1'b0, 1'b0, 1'b0);
    repeat (62) tick(320, 240, 1'b0, 1'b0, 1'b0);

    // Reset clears scores and game_over
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_sl = 4'd0; m_sr = 4'd0; m_go = 1'b0;
    expect_idle();
    tick(320, 0, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
